// File: rtl/sec_code_pkg.sv
// Shared constants and helpers for the secondary (NH / tiered) code generator.
package sec_code_pkg;

    // Default per-code storage depth in chips
    localparam int unsigned SEC_DEPTH_DEF = 128;

    // Software write granularity
    localparam int unsigned SEC_WORD_W = 32;

    // Chip counter width for a given storage depth
    function automatic int unsigned sec_cnt_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sec_code_track.sv
// One secondary code channel: word-writable chip storage, chip counter with
// load/step/wrap, current chip select and a registered wrap pulse.
module sec_code_track
    import sec_code_pkg::*;
#(
    parameter int unsigned DEPTH = SEC_DEPTH_DEF,
    parameter int unsigned CNT_W = sec_cnt_w(DEPTH),
    parameter int unsigned AW    = $clog2(DEPTH / SEC_WORD_W)
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [SEC_WORD_W-1:0] wr_data,
    input  logic [CNT_W:0]        length,
    input  logic                  load_en,
    input  logic [CNT_W-1:0]      load_val,
    input  logic                  step_req,
    output logic [CNT_W-1:0]      count,
    output logic                  cur_code,
    output logic                  wrap,
    output logic                  wrap_hit
);

    localparam int unsigned    WORDS   = DEPTH / SEC_WORD_W;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W:0] ONE_L   = (CNT_W + 1)'(1);

    logic [DEPTH-1:0] code_bits;
    logic [CNT_W:0]   eff_len;
    logic [CNT_W:0]   count_inc;
    logic             active;
    logic             step;

    // Effective length, step qualification, wrap detect and chip select
    always_comb begin
        eff_len   = (length > DEPTH_L) ? DEPTH_L : length;
        active    = (eff_len != '0);
        step      = step_req & active;
        count_inc = {1'b0, count} + ONE_L;
        wrap_hit  = step & (count_inc >= eff_len);
        cur_code  = active & code_bits[count];
    end

    // Chip storage, one 32-bit word per write
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            code_bits <= '0;
        end else if (wr_en) begin
            for (int unsigned k = 0; k < WORDS; k++) begin
                if (wr_addr == AW'(k)) begin
                    code_bits[k*SEC_WORD_W +: SEC_WORD_W] <= wr_data;
                end
            end
        end
    end

    // Chip counter and wrap pulse; a load suppresses the step and its pulse
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load_en) begin
                count <= load_val;
            end else if (step) begin
                if (wrap_hit) begin
                    count <= '0;
                    wrap  <= 1'b1;
                end else begin
                    count <= count_inc[CNT_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/secondary_code_gen.sv
// Two-channel secondary code generator. Code 2 either steps on the epoch
// strobe or, in tiered mode, only when code 1 wraps.
module secondary_code_gen
    import sec_code_pkg::*;
#(
    parameter int unsigned DEPTH = SEC_DEPTH_DEF,
    parameter int unsigned CNT_W = sec_cnt_w(DEPTH),
    parameter int unsigned AW    = $clog2(DEPTH / SEC_WORD_W)
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  code_wr_en,
    input  logic                  code_wr_sel,
    input  logic [AW-1:0]         code_wr_addr,
    input  logic [SEC_WORD_W-1:0] code_wr_data,
    input  logic [CNT_W:0]        code1_length,
    input  logic [CNT_W:0]        code2_length,
    input  logic                  code2_tiered,
    input  logic                  nh_increase,
    input  logic                  nh_count_en,
    input  logic [CNT_W-1:0]      nh_count1_i,
    input  logic [CNT_W-1:0]      nh_count2_i,
    output logic [CNT_W-1:0]      nh_count1_o,
    output logic [CNT_W-1:0]      nh_count2_o,
    output logic                  cur_code1,
    output logic                  cur_code2,
    output logic                  code1_wrap,
    output logic                  code2_wrap
);

    logic wr_en1;
    logic wr_en2;
    logic hit1;
    logic step2_req;

    // Write demux and code 2 step source selection
    always_comb begin
        wr_en1    = code_wr_en & ~code_wr_sel;
        wr_en2    = code_wr_en &  code_wr_sel;
        step2_req = code2_tiered ? hit1 : nh_increase;
    end

    sec_code_track #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .AW    (AW)
    ) u_code1 (
        .clk      (clk),
        .rst_b    (rst_b),
        .wr_en    (wr_en1),
        .wr_addr  (code_wr_addr),
        .wr_data  (code_wr_data),
        .length   (code1_length),
        .load_en  (nh_count_en),
        .load_val (nh_count1_i),
        .step_req (nh_increase),
        .count    (nh_count1_o),
        .cur_code (cur_code1),
        .wrap     (code1_wrap),
        .wrap_hit (hit1)
    );

    // Code 2 is the outer tier and never feeds another stage
    sec_code_track #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .AW    (AW)
    ) u_code2 (
        .clk      (clk),
        .rst_b    (rst_b),
        .wr_en    (wr_en2),
        .wr_addr  (code_wr_addr),
        .wr_data  (code_wr_data),
        .length   (code2_length),
        .load_en  (nh_count_en),
        .load_val (nh_count2_i),
        .step_req (step2_req),
        .count    (nh_count2_o),
        .cur_code (cur_code2),
        .wrap     (code2_wrap),
        .wrap_hit ()
    );

endmodule

// File: tb/tb_secondary_code_gen.sv
// Scoreboard bench for secondary_code_gen: the driver pushes the expected
// post-edge state for every driven cycle, the monitor pops and compares.
module tb_secondary_code_gen;

    localparam int DEPTH = 128;
    localparam int CNT_W = 7;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst_b;
    logic             code_wr_en;
    logic             code_wr_sel;
    logic [AW-1:0]    code_wr_addr;
    logic [31:0]      code_wr_data;
    logic [CNT_W:0]   code1_length;
    logic [CNT_W:0]   code2_length;
    logic             code2_tiered;
    logic             nh_increase;
    logic             nh_count_en;
    logic [CNT_W-1:0] nh_count1_i;
    logic [CNT_W-1:0] nh_count2_i;
    logic [CNT_W-1:0] nh_count1_o;
    logic [CNT_W-1:0] nh_count2_o;
    logic             cur_code1;
    logic             cur_code2;
    logic             code1_wrap;
    logic             code2_wrap;

    secondary_code_gen #(
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .code_wr_en   (code_wr_en),
        .code_wr_sel  (code_wr_sel),
        .code_wr_addr (code_wr_addr),
        .code_wr_data (code_wr_data),
        .code1_length (code1_length),
        .code2_length (code2_length),
        .code2_tiered (code2_tiered),
        .nh_increase  (nh_increase),
        .nh_count_en  (nh_count_en),
        .nh_count1_i  (nh_count1_i),
        .nh_count2_i  (nh_count2_i),
        .nh_count1_o  (nh_count1_o),
        .nh_count2_o  (nh_count2_o),
        .cur_code1    (cur_code1),
        .cur_code2    (cur_code2),
        .code1_wrap   (code1_wrap),
        .code2_wrap   (code2_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c1;
        int c2;
        int cur1;
        int cur2;
        int w1;
        int w2;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int errors = 0;
    int checks = 0;
    int seen1  = 0;
    int seen2  = 0;

    // reference state
    int          m1, m2;
    logic [31:0] mem1 [4];
    logic [31:0] mem2 [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_count1"}, 32'(nh_count1_o), 0);
        chk({tag, "_count2"}, 32'(nh_count2_o), 0);
        chk({tag, "_cur1"},   32'(cur_code1),   0);
        chk({tag, "_cur2"},   32'(cur_code2),   0);
        chk({tag, "_wrap1"},  32'(code1_wrap),  0);
        chk({tag, "_wrap2"},  32'(code2_wrap),  0);
    endtask

    function automatic int eff(input int l);
        return (l > DEPTH) ? DEPTH : l;
    endfunction

    function automatic void model_clear();
        m1 = 0;
        m2 = 0;
        for (int i = 0; i < 4; i++) begin
            mem1[i] = '0;
            mem2[i] = '0;
        end
    endfunction

    // Monitor: compare state a little after every active edge
    always @(posedge clk) begin
        #2;
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            chk("count1", 32'(nh_count1_o), mon_e.c1);
            chk("count2", 32'(nh_count2_o), mon_e.c2);
            chk("cur1",   32'(cur_code1),   mon_e.cur1);
            chk("cur2",   32'(cur_code2),   mon_e.cur2);
            chk("wrap1",  32'(code1_wrap),  mon_e.w1);
            chk("wrap2",  32'(code2_wrap),  mon_e.w2);
            if (code1_wrap === 1'b1) seen1++;
            if (code2_wrap === 1'b1) seen2++;
        end
    end

    // One driven cycle: apply inputs, advance the reference, queue the expectation
    task automatic cyc(input bit inc, input bit ld, input int ld1, input int ld2,
                       input bit we, input bit wsel, input int waddr, input logic [31:0] wdata);
        exp_t e;
        int   l1, l2;
        bit   s1, s2, h1;
        l1 = eff(int'(code1_length));
        l2 = eff(int'(code2_length));
        nh_increase  = inc;
        nh_count_en  = ld;
        nh_count1_i  = ld1[CNT_W-1:0];
        nh_count2_i  = ld2[CNT_W-1:0];
        code_wr_en   = we;
        code_wr_sel  = wsel;
        code_wr_addr = waddr[AW-1:0];
        code_wr_data = wdata;
        e.w1 = 0;
        e.w2 = 0;
        if (ld) begin
            m1 = ld1;
            m2 = ld2;
        end else begin
            s1 = inc && (l1 != 0);
            h1 = s1 && (m1 + 1 >= l1);
            s2 = (code2_tiered ? h1 : inc) && (l2 != 0);
            if (s1) begin
                if (h1) begin m1 = 0; e.w1 = 1; end
                else m1++;
            end
            if (s2) begin
                if (m2 + 1 >= l2) begin m2 = 0; e.w2 = 1; end
                else m2++;
            end
        end
        if (we) begin
            if (wsel) mem2[waddr] = wdata;
            else      mem1[waddr] = wdata;
        end
        e.c1   = m1;
        e.c2   = m2;
        e.cur1 = (l1 != 0) ? int'(mem1[m1/32][m1%32]) : 0;
        e.cur2 = (l2 != 0) ? int'(mem2[m2/32][m2%32]) : 0;
        q.push_back(e);
        @(negedge clk);
        nh_increase = 1'b0;
        nh_count_en = 1'b0;
        code_wr_en  = 1'b0;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic strobe();
        cyc(1, 0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic load(input int v1, input int v2);
        cyc(0, 1, v1, v2, 0, 0, 0, 32'h0);
    endtask

    task automatic wr(input bit sel, input int addr, input logic [31:0] data);
        cyc(0, 0, 0, 0, 1, sel, addr, data);
    endtask

    task automatic strobes(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            strobe();
            if (gap) idle();
        end
    endtask

    task automatic chk_wraps(input string tag, input int e1, input int e2);
        chk({tag, "_wraps1"}, seen1, e1);
        chk({tag, "_wraps2"}, seen2, e2);
        seen1 = 0;
        seen2 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_b        = 1'b0;
        code_wr_en   = 1'b0;
        code_wr_sel  = 1'b0;
        code_wr_addr = '0;
        code_wr_data = '0;
        code1_length = '0;
        code2_length = '0;
        code2_tiered = 1'b0;
        nh_increase  = 1'b0;
        nh_count_en  = 1'b0;
        nh_count1_i  = '0;
        nh_count2_i  = '0;
        model_clear();

        #3;
        chk_zero("reset");
        @(negedge clk);
        rst_b = 1'b1;

        // Independent NH codes
        wr(0, 0, 32'h0000_0359);
        wr(1, 0, 32'h0000_4D4E);
        code1_length = 25;
        code2_length = 20;
        seen1 = 0;
        seen2 = 0;
        strobes(50, 1);
        chk_wraps("nh", 2, 2);
        chk("nh_end_count1", 32'(nh_count1_o), 0);
        chk("nh_end_count2", 32'(nh_count2_o), 10);

        // Long code, back-to-back strobes, then disabled
        code2_length = 0;
        wr(0, 0, 32'hDEAD_BEEF);
        wr(0, 1, 32'h1234_5678);
        wr(0, 2, 32'hA5A5_F00F);
        wr(0, 3, 32'h0F0F_3C3C);
        code1_length = 100;
        strobes(200, 0);
        chk_wraps("long", 2, 0);
        code1_length = 0;
        strobes(10, 1);
        chk_wraps("off", 0, 0);

        // Tiered: code 2 steps on code 1 wraps only
        load(0, 0);
        code1_length = 4;
        code2_length = 5;
        code2_tiered = 1'b1;
        strobes(20, 1);
        chk_wraps("tier", 5, 1);

        // Load versus step
        code2_tiered = 1'b0;
        code1_length = 25;
        code2_length = 20;
        load(24, 3);
        strobe();
        cyc(1, 1, 24, 3, 0, 0, 0, 32'h0);
        idle();
        load(30, 3);
        strobe();
        chk_wraps("load", 2, 0);

        // L = 1 and clamping
        code2_length = 0;
        code1_length = 1;
        strobes(5, 1);
        chk_wraps("len1", 5, 0);
        code1_length = 200;
        load(126, 0);
        strobes(2, 1);
        chk_wraps("clamp", 1, 0);

        // Writes while running, including a write in a step cycle
        code1_length = 25;
        load(0, 0);
        strobes(3, 0);
        wr(0, 0, 32'hFFFF_FFF7);
        cyc(1, 0, 0, 0, 1, 0, 0, 32'h0000_0010);
        idle();

        // Asynchronous reset mid-run
        #1 rst_b = 1'b0;
        #1 chk_zero("midrst");
        #1 rst_b = 1'b1;
        model_clear();
        @(negedge clk);
        idle();
        strobes(2, 1);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        chk("drain", 32'(q.size()), 0);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/secondary_code_gen.md
# secondary_code_gen

Parametrised two-channel secondary (NH / tiered) code generator for the correlator channel. It holds two secondary code sequences of up to DEPTH bits each in internal storage that software writes in 32-bit words. It steps each sequence on primary-code epochs and supplies the current secondary chip, the count and an epoch-wrap pulse to the correlator. Code 2 can run either independently or as the outer tier of a tiered code, where it advances only when code 1 wraps.

## Interface
- DEPTH, 128: maximum secondary code length in bits, per code. Must be a multiple of 32 and at least 32.
- CNT_W, $clog2(DEPTH): count width.
- AW, $clog2(DEPTH/32): word address width.
- clk  in  1  system clock
- rst_b  in  1  reset; one clock, asynchronous, active-low
- code_wr_en  in  1  write one 32-bit code word
- code_wr_sel  in  1  0 = code 1 storage, 1 = code 2 storage
- code_wr_addr  in  AW  word index; bit n of word k is chip 32k+n
- code_wr_data  in  32  code word
- code1_length  in  CNT_W+1  code 1 length in chips; 0 = disabled
- code2_length  in  CNT_W+1  code 2 length in chips; 0 = disabled
- code2_tiered  in  1  1 = code 2 advances on code 1 wrap, not on nh_increase
- nh_increase  in  1  primary-code epoch strobe, 1 cycle
- nh_count_en  in  1  load both counters, used for channel state restore
- nh_count1_i  in  CNT_W  code 1 load value
- nh_count2_i  in  CNT_W  code 2 load value
- nh_count1_o  out  CNT_W  code 1 current chip index
- nh_count2_o  out  CNT_W  code 2 current chip index
- cur_code1  out  1  current code 1 chip
- cur_code2  out  1  current code 2 chip
- code1_wrap  out  1  code 1 wrapped to chip 0, 1-cycle pulse
- code2_wrap  out  1  code 2 wrapped to chip 0, 1-cycle pulse

## Operation
- **Effective length:** L = min(length, DEPTH). L = 0 disables that code: its counter holds, its cur_code is 0 and it produces no wrap.
- **Code 1 step:** step1 = nh_increase & (L1≠0).
- **Code 2 step:** step2 = code2_tiered ? (step1 & wrap condition of code 1) : (nh_increase & (L2≠0)). In both cases step2 also requires L2≠0.
- **Wrap condition:** on a step, if count+1 ≥ L, the counter goes to 0 and the wrap pulse fires. Otherwise the counter increments. The comparison uses CNT_W+1 bits.
  - L = 1: the counter stays 0 and wrap fires on every step.
  - A count loaded at or above L wraps to 0 on the next step.
- **Priority per counter:**
  - nh_count_en load beats step. A load cycle produces no wrap pulse for either code, including a tiered code 2 step.
- **Chip selection:**
  - cur_codeX = stored bit[countX] when LX≠0, otherwise 0.
  - The selection is combinational from the counter register and the storage.
- **Writes:**
  - A write updates 32 storage bits at the next edge.
  - Writes are legal while the code is running; the new bit is seen from the next cycle.
  - Writes do not affect the counters.
- **Length or mode change mid-run:** takes effect on the next step. The counter is not cleared.

## Timing
- **Reset:** all counters, all storage bits, cur_code1/2 and code1/2_wrap are 0.
- **Step latency:** the counter updates at the edge after the nh_increase cycle, and cur_code follows in that same cycle.
- **Wrap pulse:**
  - Registered and high for exactly the one cycle in which the counter first reads 0 after wrapping.
  - In tiered mode, code1_wrap and code2_wrap are coincident.
- **Back-to-back strobes:** nh_increase may be asserted every cycle, and each assertion is one step.
- **Simultaneous write and step:** the step reads the pre-write bit in the current cycle.
- **Reset mid-run:** asynchronous clear of all state. Storage must be rewritten afterwards.

## Structure
- **Package:** shared package `sec_code_pkg` holds the DEPTH default, the 32-bit word width constant and a CNT_W helper function.
- **Sub-module:** one sub-module `sec_code_track`, instantiated twice. It contains the DEPTH-bit storage with its word write, the counter with load/step/wrap logic, the bit select and the registered wrap pulse.
- **Top level:** holds only the write demultiplexing and the step2/tier selection.

## Test plan
- **Independent NH codes:** DEPTH=128. Write code1 word0 = 0x0000_0359 with L1=25, and code2 word0 = 0x0000_4D4E with L2=20. Apply 50 nh_increase strobes.
  - cur_code1 and cur_code2 follow bit[n mod L] of their words.
  - code1_wrap pulses after strobes 25 and 50.
  - code2_wrap pulses after strobes 20 and 40.
- **Long code:** L1=100, with all 4 words written with a known pattern. Apply 200 strobes.
  - Sequence matches the pattern.
  - Counter wraps 99→0 twice.
  - cur_code1 is 0 throughout while L1=0.
- **Tiered mode:** code2_tiered=1, L1=4, L2=5. Apply 20 strobes.
  - nh_count2_o advances only on code1 wraps (strobes 4, 8, …).
  - code2_wrap fires once, at strobe 20, coincident with code1_wrap.
- **Load vs step:** nh_count_en with nh_count1_i=24, L1=25.
  - Next step gives count 0 plus a wrap pulse.
  - Load with nh_increase in the same cycle: counter=24 and no wrap pulse.
  - Loading 30 with L1=25 gives 0 on the next step.
- **Boundaries:**
  - L=1: wrap pulses on every strobe, count stays 0.
  - Length > DEPTH is clamped to 128.
  - Writing word0 while running changes cur_code1 the next cycle.
  - Asserting rst_b low mid-run zeroes all outputs immediately.
